icache_line_responder: RTL and testbench
========================================

Name: icache_line_responder

Overview:
- Memory-side responder for the instruction cache's line-refill interface.
- Accepts a refill request (valid + miss address) and fetches one cache line word-by-word from a word-wide synchronous BRAM (1-cycle read latency).
- Assembles the words into a CACHE_LINE_WIDTH line and returns it with a ready handshake.
- Sits between the ICache miss path and instruction memory, in place of direct BRAM fetch.

Parameters:
- WORD, 32: data word width in bits.
- LINE_WORDS, 4: words per cache line; power of two, ≥2.
- RAM_DEPTH_LOG, 10: BRAM word-address width.
- ADDR_W, 32: request byte-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- flush  in  1  abort any in-flight or completed refill (branch redirect).
- req_valid  in  1  refill request from ICache; held until req_ready is seen.
- req_addr  in  ADDR_W  byte address of the missing instruction.
- req_ready  out  1  line_data is valid.
- line_data  out  LINE_WORDS*WORD  assembled line; word i occupies bits [WORD*i+WORD-1 : WORD*i].
- busy  out  1  fill in progress (READ or DRAIN states).
- mem_en  out  1  BRAM read enable.
- mem_addr  out  RAM_DEPTH_LOG  BRAM word address.
- mem_dout  in  WORD  BRAM read data, valid in the cycle after mem_en.

Behaviour:
- Reset: rst=0 forces IDLE immediately; req_ready, busy, mem_en, mem_addr, line_data and all counters go to 0. This applies mid-fill too.
- Line base = req_addr with the low log2(LINE_WORDS)+2 bits cleared. Word index = (byte address >> 2) truncated to RAM_DEPTH_LOG bits, so addresses alias modulo the RAM depth.
- States:
  - IDLE: if req_valid=1 and flush=0, latch the base address, go to READ. Otherwise stay.
  - READ: mem_en=1 for exactly LINE_WORDS consecutive cycles. mem_addr steps through base..base+LINE_WORDS-1 (or the wrapped order, see Optional Feature). After the last issue, go to DRAIN.
  - DRAIN: one cycle capturing the final word, then go to DONE.
  - DONE: req_ready=1. Stay while req_valid=1; go to IDLE on the cycle after req_valid=0.
- mem_en, mem_addr, req_ready and busy are registered outputs.
- Data capture: the word issued in cycle k is written into its line slot at the end of cycle k+1.
- Latency: acceptance on the edge ending cycle 0; issues in cycles 1..LINE_WORDS; req_ready first high in cycle LINE_WORDS+2 (6 for the default LINE_WORDS=4).
- line_data stays stable from DONE until the next acceptance.
- If req_valid drops mid-fill without flush, the fill completes and req_ready pulses for one cycle.
- flush=1:
  - In any state, go to IDLE on the next edge.
  - mem_en=0 and req_ready=0 from the next cycle.
  - Outstanding read data is discarded; line_data is unchanged.
- flush and req_valid in the same IDLE cycle: flush wins, no acceptance.
- Back-to-back requests need at least one cycle with req_valid=0 between them.

Optional Feature:
- Macro: ICACHE_CRITICAL_WORD_FIRST_EN.
- Defined: fetch order starts at the word offset of req_addr and wraps modulo LINE_WORDS (offset 3 of 4 → 3,0,1,2). Slot placement in line_data is unchanged; latency is unchanged.
- Undefined: fetch order is always word 0 first.

Decomposition:
- Shared header, alongside the existing CPU parameter header:
  - WORD, RAM_DEPTH_LOG and CACHE_LINE_WIDTH (= LINE_WORDS*WORD) macros.
  - 2-bit state encoding: IDLE=0, READ=1, DRAIN=2, DONE=3.
- One sub-module: icache_line_assembler. It holds the line register, a write strobe and a slot index, and supports clear-on-reset.
- The FSM, issue counter and address generation stay in the top module.

Test Plan:
- Reset: assert rst=0 during READ → same cycle: mem_en=0, busy=0, req_ready=0, line_data=0. Release rst=1 with req_valid=0 → state remains IDLE.
- Basic fill: BRAM word[i]=0x1000+i; req_addr=0x14 → mem_addr=4,5,6,7 in cycles 1-4; req_ready=1 in cycle 6; line_data={0x1007,0x1006,0x1005,0x1004}.
- Handshake: hold req_valid=1 for 3 cycles after req_ready → req_ready stays 1. Drop req_valid → req_ready=0 next cycle. Idle one cycle, then req_addr=0x20 → mem_addr=8..11.
- Flush mid-fill: flush=1 in cycle 3 → mem_en=0 from cycle 4; req_ready never rises; line_data keeps its previous value. A following req_addr=0x14 returns the correct line.
- Critical word first (macro defined): req_addr=0x1C → mem_addr=7,4,5,6; line_data identical to the basic-fill result.
- Depth wrap: req_addr=0xFF0 → mem_addr=1020..1023. req_addr=0x1000 → mem_addr=0..3, reading the same data as address 0.

Source files
------------

// File: rtl/icache_line_responder_pkg.sv
// Shared constants and refill-FSM encoding for the ICache line responder.
// CACHE_LINE_WIDTH is the default assembled line width (LINE_WORDS * WORD).
package icache_line_responder_pkg;

    localparam int unsigned CPU_WORD          = 32;
    localparam int unsigned CPU_LINE_WORDS    = 4;
    localparam int unsigned CPU_RAM_DEPTH_LOG = 10;
    localparam int unsigned CPU_ADDR_W        = 32;
    localparam int unsigned CACHE_LINE_WIDTH  = CPU_LINE_WORDS * CPU_WORD;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

endpackage

// File: rtl/icache_line_responder_if.sv
// Refill request/response bundle between the ICache miss path (master)
// and the line responder (slave).
interface icache_line_responder_if
    import icache_line_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned LINE_W = CACHE_LINE_WIDTH
);

    logic              flush;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic [LINE_W-1:0] line_data;
    logic              busy;

    modport master (
        output flush, req_valid, req_addr,
        input  req_ready, line_data, busy
    );

    modport slave (
        input  flush, req_valid, req_addr,
        output req_ready, line_data, busy
    );

endinterface

// File: rtl/icache_line_assembler.sv
// Collects BRAM words into line slots; the visible line only updates on commit,
// so an aborted fill never disturbs the previously returned line.
module icache_line_assembler #(
    parameter int unsigned WORD       = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_slot,
    input  logic [WORD-1:0]              wr_data,
    input  logic                         commit,
    output logic [LINE_WORDS*WORD-1:0]   line_data
);

    localparam int unsigned SLOT_W = $clog2(LINE_WORDS);

    logic [LINE_WORDS*WORD-1:0] fill_q, fill_d, line_q;

    always_comb begin
        fill_d = fill_q;
        for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            if (wr_en && (wr_slot == SLOT_W'(i)))
                fill_d[i*WORD +: WORD] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_q <= '0;
            line_q <= '0;
        end else begin
            fill_q <= fill_d;
            if (commit)
                line_q <= fill_d;
        end
    end

    assign line_data = line_q;

endmodule

// File: rtl/icache_line_responder.sv
// ICache line-refill responder: fetches one line word-by-word from a 1-cycle BRAM.
// Optional macro ICACHE_CRITICAL_WORD_FIRST_EN starts the fetch at the missing word.
module icache_line_responder
    import icache_line_responder_pkg::*;
#(
    parameter int unsigned WORD          = CPU_WORD,
    parameter int unsigned LINE_WORDS    = CPU_LINE_WORDS,
    parameter int unsigned RAM_DEPTH_LOG = CPU_RAM_DEPTH_LOG,
    parameter int unsigned ADDR_W        = CPU_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    icache_line_responder_if.slave   bus,
    output logic                     mem_en,
    output logic [RAM_DEPTH_LOG-1:0] mem_addr,
    input  logic [WORD-1:0]          mem_dout
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned TAG_W = RAM_DEPTH_LOG - OFF_W;

    fill_state_t              state_q, state_d;
    logic [OFF_W-1:0]         cnt_q, cnt_d, off_q, off_d, req_off, issue_off;
    logic [TAG_W-1:0]         tag_q, tag_d;
    logic [RAM_DEPTH_LOG-1:0] req_word, mem_addr_d;
    logic                     mem_en_d, req_ready_q, req_ready_d, busy_q, busy_d;
    logic                     rd_pend_q;
    logic [OFF_W-1:0]         rd_slot_q;
    logic                     accept;
    logic                     unused_addr;

    assign req_word    = bus.req_addr[RAM_DEPTH_LOG+1:2];
    assign unused_addr = ^bus.req_addr;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign req_off = req_word[OFF_W-1:0];
`else
    assign req_off = '0;
`endif

    assign accept = (state_q == IDLE) && bus.req_valid && !bus.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tag_q       <= '0;
            off_q       <= '0;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_slot_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            off_q       <= off_d;
            mem_en      <= mem_en_d;
            mem_addr    <= mem_addr_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rd_pend_q   <= mem_en & ~bus.flush;
            rd_slot_q   <= mem_addr[OFF_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ:    if (bus.flush) state_d = IDLE;
                     else if (cnt_q == OFF_W'(LINE_WORDS - 1)) state_d = DRAIN;
            DRAIN:   state_d = bus.flush ? IDLE : DONE;
            DONE:    state_d = (bus.flush || !bus.req_valid) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        cnt_d       = '0;
        tag_d       = tag_q;
        off_d       = off_q;
        issue_off   = '0;
        mem_en_d    = 1'b0;
        mem_addr_d  = '0;
        busy_d      = (state_d == READ) || (state_d == DRAIN);
        req_ready_d = (state_d == DONE);
        if (accept) begin
            tag_d      = req_word[RAM_DEPTH_LOG-1:OFF_W];
            off_d      = req_off;
            mem_en_d   = 1'b1;
            mem_addr_d = {req_word[RAM_DEPTH_LOG-1:OFF_W], req_off};
        end else if (state_q == READ && state_d == READ) begin
            cnt_d      = cnt_q + OFF_W'(1);
            issue_off  = off_q + cnt_d;
            mem_en_d   = 1'b1;
            mem_addr_d = {tag_q, issue_off};
        end
    end

    icache_line_assembler #(
        .WORD       (WORD),
        .LINE_WORDS (LINE_WORDS)
    ) u_assembler (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (rd_pend_q & ~bus.flush),
        .wr_slot   (rd_slot_q),
        .wr_data   (mem_dout),
        .commit    ((state_q == DRAIN) & ~bus.flush),
        .line_data (bus.line_data)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_icache_line_responder.sv
// Scoreboard bench for icache_line_responder: directed refills against a BRAM model.
module tb_icache_line_responder;

    typedef struct {
        logic [31:0]  addr;
        logic [39:0]  seq;   // expected issue order, first word in the top 10 bits
        logic [127:0] line;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] ram [1024];
    int          cyc;
    int          n_vec;
    int          n_bad;
    vec_t        vecs [6];

    logic [9:0]   exp_addr [$];
    logic [127:0] exp_line [$];
    int           exp_rcyc [$];
    logic         ready_prev;

    icache_line_responder_if #(.ADDR_W(32), .LINE_W(128)) bus ();

    icache_line_responder #(
        .WORD          (32),
        .LINE_WORDS    (4),
        .RAM_DEPTH_LOG (10),
        .ADDR_W        (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    always @(posedge clk) if (mem_en) mem_dout <= ram[mem_addr];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 128'(act), 128'(exp));
    endtask

    function automatic logic [9:0] seq_at(input logic [39:0] s, input int i);
        return s[(3 - i)*10 +: 10];
    endfunction

    // Monitor: every BRAM issue and every rising req_ready pops the scoreboard.
    initial ready_prev = 1'b0;
    always @(negedge clk) begin
        if (rst && mem_en) begin
            if (exp_addr.size() == 0) check("unexpected_issue", 128'(mem_addr), 128'h3ff_dead);
            else check("mem_addr", 128'(mem_addr), 128'(exp_addr.pop_front()));
        end
        if (rst && bus.req_ready && !ready_prev) begin
            if (exp_line.size() == 0) check1("unexpected_ready", 1'b1, 1'b0);
            else begin
                check("line_data", bus.line_data, exp_line.pop_front());
                check("ready_cycle", 128'(cyc), 128'(exp_rcyc.pop_front()));
            end
        end
        ready_prev = bus.req_ready;
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
        end
        if (!ok) check1("ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_fill(input int v, input int hold, input int drop_at);
        int acc;
        bit ok;
        @(posedge clk); #1;
        bus.req_addr  = vecs[v].addr;
        bus.req_valid = 1'b1;
        acc = cyc;
        for (int i = 0; i < 4; i++) exp_addr.push_back(seq_at(vecs[v].seq, i));
        exp_line.push_back(vecs[v].line);
        exp_rcyc.push_back(acc + 6);
        if (drop_at > 0) begin
            repeat (drop_at) @(posedge clk);
            #1 bus.req_valid = 1'b0;
        end
        wait_ready(ok);
        if (ok) begin
            if (drop_at > 0) begin
                @(negedge clk);
                check1("ready_pulse", bus.req_ready, 1'b0);
            end else begin
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    check1("ready_hold", bus.req_ready, 1'b1);
                end
                @(posedge clk); #1 bus.req_valid = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check1("ready_drop", bus.req_ready, 1'b0);
            end
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, vectors %0d", n_vec);
        $fatal(1, "simulation time limit");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h1000 + i;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        vecs[0] = '{32'h14,  {10'd5, 10'd6, 10'd7, 10'd4},         128'h00001007_00001006_00001005_00001004};
        vecs[2] = '{32'h1C,  {10'd7, 10'd4, 10'd5, 10'd6},         128'h00001007_00001006_00001005_00001004};
        vecs[5] = '{32'h3A8, {10'd234, 10'd235, 10'd232, 10'd233}, 128'h000010eb_000010ea_000010e9_000010e8};
`else
        vecs[0] = '{32'h14,  {10'd4, 10'd5, 10'd6, 10'd7},         128'h00001007_00001006_00001005_00001004};
        vecs[2] = '{32'h1C,  {10'd4, 10'd5, 10'd6, 10'd7},         128'h00001007_00001006_00001005_00001004};
        vecs[5] = '{32'h3A8, {10'd232, 10'd233, 10'd234, 10'd235}, 128'h000010eb_000010ea_000010e9_000010e8};
`endif
        vecs[1] = '{32'h20,   {10'd8, 10'd9, 10'd10, 10'd11},        128'h0000100b_0000100a_00001009_00001008};
        vecs[3] = '{32'hFF0,  {10'd1020, 10'd1021, 10'd1022, 10'd1023}, 128'h000013ff_000013fe_000013fd_000013fc};
        vecs[4] = '{32'h1000, {10'd0, 10'd1, 10'd2, 10'd3},         128'h00001003_00001002_00001001_00001000};

        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        @(negedge clk);
        check1("rst_mem_en", mem_en, 1'b0);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_ready", bus.req_ready, 1'b0);
        check("rst_line", bus.line_data, '0);
        check("rst_mem_addr", 128'(mem_addr), '0);
        @(posedge clk); #1 rst = 1'b1;

        run_fill(0, 3, 0);
        run_fill(1, 0, 0);

        // Flush in cycle 3 of a fill: three issues seen, then nothing.
        @(posedge clk); #1;
        bus.req_addr  = vecs[0].addr;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) exp_addr.push_back(seq_at(vecs[0].seq, i));
        repeat (3) @(posedge clk);
        #1 bus.flush = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1 bus.flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check1("flush_mem_en", mem_en, 1'b0);
            check1("flush_ready", bus.req_ready, 1'b0);
        end
        check("flush_line_kept", bus.line_data, vecs[1].line);
        run_fill(0, 0, 0);

        run_fill(2, 0, 0);
        run_fill(3, 0, 0);
        run_fill(4, 0, 0);
        run_fill(5, 0, 2);

        // Flush and request together in IDLE: no acceptance.
        @(posedge clk); #1;
        bus.req_addr  = vecs[1].addr;
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        @(negedge clk);
        check1("flush_win_busy", bus.busy, 1'b0);
        check1("flush_win_mem_en", mem_en, 1'b0);

        // Reset during READ clears outputs within the same cycle.
        @(posedge clk); #1;
        bus.req_addr  = vecs[0].addr;
        bus.req_valid = 1'b1;
        exp_addr.push_back(seq_at(vecs[0].seq, 0));
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        check1("midrst_mem_en", mem_en, 1'b0);
        check1("midrst_busy", bus.busy, 1'b0);
        check1("midrst_ready", bus.req_ready, 1'b0);
        check("midrst_line", bus.line_data, '0);
        bus.req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check1("post_rst_busy", bus.busy, 1'b0);
        check1("post_rst_mem_en", mem_en, 1'b0);
        run_fill(1, 1, 0);

        repeat (4) @(negedge clk);
        check("left_issues", 128'(exp_addr.size()), '0);
        check("left_lines", 128'(exp_line.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
